// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage states, reset PC and per-stage payload widths
package pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
  localparam logic [31:0] PC_RESET = 32'h8000_0000;
  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 160;
  localparam int EXMEM_W = 112;
  localparam int MEMWB_W = 72;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready stage register with a two-entry skid buffer and flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              accept, drain;
  assign in_ready  = state_q != ST_FULL;
  assign out_valid = state_q != ST_EMPTY;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_HALF;
          main_d  = in_data;
        end
        ST_HALF: if (accept && drain) main_d = in_data;
        else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (drain) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
        end
        ST_FULL: if (drain) begin
          state_d = ST_HALF;
          main_d  = skid_q;
          skid_d  = BUBBLE_VAL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three stage widths (64, 1, 200) checked every cycle against a FIFO queue model
module tb_pipe_stage_reg;
  localparam logic [199:0] RV_ALL = {136'h5A, 64'h0000_0000_8000_0000};
  localparam logic [199:0] BV_ALL = {136'h3C, 64'h0000_0000_DEAD_0001};
  logic clk = 1'b0;
  logic [2:0] rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [199:0] din[3];
  logic [199:0] dout[3];
  logic [1:0] occ[3];
  logic [199:0] msk[3];
  logic [199:0] idle[3];
  logic [199:0] exp_q[3][$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = g == 0 ? 64 : g == 1 ? 1 : 200;
    logic [W-1:0] od;
    pipe_stage_reg #(
      .DATA_W(W), .RESET_VAL(RV_ALL[W-1:0]), .BUBBLE_VAL(BV_ALL[W-1:0])
    ) u_dut (
      .clk(clk), .reset_n(rst_n[g]), .flush(flush[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(din[g][W-1:0]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(od),
      .occupancy(occ[g])
    );
    assign dout[g] = 200'(od);
  end
  function automatic int wid(int i);
    return i == 0 ? 64 : i == 1 ? 1 : 200;
  endfunction
  function void chk(string nm, int i, logic [199:0] act, logic [199:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[w=%0d] t=%0t: got %0h expected %0h", nm, wid(i), $time, act, expv);
    end
  endfunction
  // Scoreboard: compare outputs with the model, then apply this cycle's handshakes
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int sz;
      bit acc, drn;
      if (!rst_n[i]) begin
        exp_q[i].delete();
        idle[i] = RV_ALL & msk[i];
      end
      sz = exp_q[i].size();
      chk("occupancy", i, 200'(occ[i]), 200'(sz));
      chk("out_valid", i, 200'(out_valid[i]), 200'(sz > 0));
      chk("in_ready", i, 200'(in_ready[i]), 200'(sz < 2));
      chk("out_data", i, dout[i], sz > 0 ? exp_q[i][0] : idle[i]);
      if (rst_n[i]) begin
        acc = in_valid[i] && sz < 2;
        drn = out_ready[i] && sz > 0;
        if (flush[i]) begin
          exp_q[i].delete();
          idle[i] = BV_ALL & msk[i];
        end else begin
          if (drn) void'(exp_q[i].pop_front());
          if (acc) exp_q[i].push_back(din[i] & msk[i]);
          if (drn && exp_q[i].size() == 0) idle[i] = BV_ALL & msk[i];
        end
      end
    end
  end
  task automatic step(int i, bit v, logic [199:0] d, bit r, bit f, bit rn = 1'b1);
    @(posedge clk);
    #1;
    in_valid[i]  = v;
    din[i]       = d & msk[i];
    out_ready[i] = r;
    flush[i]     = f;
    rst_n[i]     = rn;
  endtask
  task automatic rand_run(int i, int n);
    for (int k = 0; k < n; k++) begin
      logic [199:0] d;
      d = '0;
      for (int w = 0; w < 7; w++) d = {d[167:0], $urandom()};
      step(i, $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 499) != 0);
    end
  endtask
  task automatic directed();
    for (int k = 1; k <= 16; k++) step(0, 1, 200'(k), 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 200'hA, 1, 0);
    step(0, 1, 200'hB, 0, 0);
    repeat (3) step(0, 1, 200'hC, 0, 0);
    step(0, 1, 200'hC, 1, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 1, 200'h11, 0, 0);
    step(0, 1, 200'h22, 0, 0);
    step(0, 1, 200'h33, 1, 1);
    repeat (2) step(0, 0, 0, 1, 0);
    step(0, 1, 200'h55, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 1, 200'h66, 0, 0);
    step(0, 1, 200'h77, 0, 0);
    step(0, 1, 200'h88, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      msk[i]       = (200'(1) << wid(i)) - 200'(1);
      idle[i]      = RV_ALL & msk[i];
      din[i]       = '0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      flush[i]     = 1'b0;
      rst_n[i]     = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = '1;
    fork
      rand_run(1, 10000);
      rand_run(2, 10000);
      begin
        directed();
        rand_run(0, 10000);
      end
    join
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register for the CPU datapath: the generic successor to the fixed-field inter-stage latches. It carries an opaque payload bus between two stages with a valid/ready handshake and a two-entry skid buffer, so back-pressure does not create a combinational ready path. It supports synchronous flush to a configurable bubble value and a distinct configurable reset value. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB, with each stage's control and data fields concatenated onto `in_data`.

## Interface
Parameters:
- `DATA_W`, 64: payload width in bits; any value ≥ 1.
- `RESET_VAL`, `{DATA_W{1'b0}}`: `out_data` value after reset. The ID/EX instance places `PC_RESET` in its PC field.
- `BUBBLE_VAL`, `{DATA_W{1'b0}}`: payload loaded on flush and on drain-to-empty. All control fields are 0, so a bubble is a NOP.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all held entries.
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry; registered.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  DATA_W  head payload; registered.
- `occupancy`  out  2  entries held: 0, 1 or 2.

## Operation
- Handshake events:
  - accept = `in_valid & in_ready`.
  - drain = `out_valid & out_ready`.
- Storage: main register (drives `out_data`) and skid register.
- States and encoding: EMPTY (0), HALF (1), FULL (2). `occupancy` equals the state encoding.
- Derived outputs: `in_ready` = (state != FULL); `out_valid` = (state != EMPTY).
- Transitions:
  - EMPTY, accept → HALF; main ← `in_data`.
  - EMPTY, otherwise → hold.
  - HALF, accept & drain → HALF; main ← `in_data`.
  - HALF, accept & !drain → FULL; skid ← `in_data`.
  - HALF, drain & !accept → EMPTY; main ← `BUBBLE_VAL`.
  - HALF, neither → hold.
  - FULL, drain → HALF; main ← skid, skid ← `BUBBLE_VAL`.
  - FULL, no drain → hold. Accept is impossible because `in_ready` = 0.
- Flush (priority below reset, above everything else):
  - Next state EMPTY; main and skid ← `BUBBLE_VAL`.
  - An accept or drain in the flush cycle is discarded. Upstream sees the handshake complete, but the payload is dropped.
- Reset (`reset_n` low, any cycle, including mid-transfer):
  - State → EMPTY; main ← `RESET_VAL`; skid ← `BUBBLE_VAL`.
  - Outputs: `out_valid` 0, `in_ready` 1, `occupancy` 0, `out_data` = `RESET_VAL`.
- Ordering: strictly FIFO; the skid entry is always younger than the main entry.
- When `out_valid` = 0, `out_data` is `BUBBLE_VAL`, or `RESET_VAL` if no accept has occurred since reset. It is never stale payload.
- `in_data` is ignored when accept is false.

## Timing
- Latency: an entry accepted at edge N is on `out_data` with `out_valid` = 1 after edge N. Downstream sees it in cycle N+1.
- Throughput: 1 entry/cycle while `out_ready` = 1.
- Stall: the first stall cycle is absorbed by the skid register. `in_ready` falls one cycle after `out_ready` falls, with the stage FULL.
- Recovery: the first drain from FULL raises `in_ready` on the next cycle.
- Flush: asserted in cycle N, it gives `out_valid` = 0 and `in_ready` = 1 from cycle N+1.
- No combinational path from any input to any output. All outputs come from flops.
- Reset assertion is asynchronous. Deassertion is assumed to be synchronised externally to `clk`.

## Structure
- Shared package `pipe_pkg`:
  - State localparams `ST_EMPTY`, `ST_HALF`, `ST_FULL` (2-bit).
  - `PC_RESET` = 32'h8000_0000.
  - Per-stage payload width constants (`IDEX_W` etc.).
- Single module, no sub-module. The two-register skid datapath is small enough to stay inline.

## Test plan
- Reset: drive `reset_n` = 0 mid-stream with FULL state, `RESET_VAL` = 64'h8000_0000 → immediately `out_valid` = 0, `in_ready` = 1, `occupancy` = 0, `out_data` = 64'h8000_0000.
- Streaming: send 16 payloads 0x1..0x10 back-to-back with `out_ready` = 1 → outputs appear one cycle later, in order, 1/cycle; `occupancy` stays 1.
- Stall:
  - Stimulus: with `out_ready` = 1, send 0xA then 0xB on consecutive cycles; drop `out_ready` on the cycle 0xB is accepted; continue offering 0xC.
  - Required: state goes FULL, `in_ready` = 0, `out_data` = 0xA held, 0xC not accepted.
  - Release: raise `out_ready` → 0xA, 0xB, 0xC out in order with no loss or duplication.
- Flush while FULL with simultaneous accept attempt and drain → next cycle `out_valid` = 0, `out_data` = `BUBBLE_VAL`, `occupancy` = 0; the flushed payloads never appear.
- Drain to empty: single payload 0x55, then `in_valid` = 0 → after the drain, `out_valid` = 0 and `out_data` = `BUBBLE_VAL`.
- Random valid/ready (10k cycles, `DATA_W` = 1 and 200) against a reference queue model → exact order match, and `occupancy` equals the model depth every cycle.
